// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the fetch PC, keeps at most one imem request in
// flight and buffers returned words with their PC in a small queue for decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4
);
  localparam int unsigned     PW      = $clog2(DEPTH);
  localparam logic [PW:0]     DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [31:0]     NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [31:0]   fetch_pc_r, fetch_pc_s, req_pc_r;
  logic [31:0]   q_instr_r [DEPTH];
  logic [31:0]   q_pc_r    [DEPTH];
  logic [PW-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_s, wr_ptr_s;
  logic [PW:0]   count_r, count_s;
  logic          push_s, pop_s, slot_free_s, grant_s;
  logic          valid_s;
  logic [31:0]   instr_s, pc_s;

  assign imem_addr = fetch_pc_r;
  assign grant_s   = (state_r == REQ) && imem_gnt;
  assign pop_s     = instr_valid && instr_ready;
  // A redirect drops any response arriving in the same cycle.
  assign push_s    = (state_r == WAIT) && imem_rvalid && !PCSrc && ((count_r != DEPTH_C) || pop_s);

  // Queue pointer/count update; a redirect empties the queue outright.
  always_comb begin
    count_s  = count_r;
    rd_ptr_s = rd_ptr_r;
    wr_ptr_s = wr_ptr_r;
    if (PCSrc) begin
      count_s  = '0;
      rd_ptr_s = '0;
      wr_ptr_s = '0;
    end else begin
      if (push_s) begin
        wr_ptr_s = wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_s = rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      count_s = count_r + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
    end
    slot_free_s = (count_s < DEPTH_C);
  end

  // Next fetch state and fetch PC.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = (slot_free_s || PCSrc) ? REQ : IDLE;
      REQ: begin
        if (imem_gnt) begin
          state_s = PCSrc ? DRAIN : WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_s = slot_free_s ? REQ : IDLE;
        end else if (PCSrc) begin
          state_s = DRAIN;
        end else begin
          state_s = WAIT;
        end
      end
      DRAIN:   state_s = imem_rvalid ? REQ : DRAIN;
      default: state_s = IDLE;
    endcase
    if (PCSrc) begin
      fetch_pc_s = PCTarget & ~32'h0000_0003;
    end else if (grant_s) begin
      fetch_pc_s = fetch_pc_r + 32'd4;
    end else begin
      fetch_pc_s = fetch_pc_r;
    end
  end

  // Next head of queue; bypass the storage when the pushed word becomes the head.
  always_comb begin
    valid_s = (count_s != '0);
    if (count_s == '0) begin
      instr_s = NOP;
      pc_s    = 32'h0000_0000;
    end else if (push_s && (rd_ptr_s == wr_ptr_r)) begin
      instr_s = imem_rdata;
      pc_s    = req_pc_r;
    end else begin
      instr_s = q_instr_r[rd_ptr_s];
      pc_s    = q_pc_r[rd_ptr_s];
    end
  end

  // Queue storage, written only on push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_instr_r[wr_ptr_r] <= imem_rdata;
      q_pc_r[wr_ptr_r]    <= req_pc_r;
    end
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      fetch_pc_r  <= RESET_PC;
      req_pc_r    <= RESET_PC;
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      count_r     <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      Instr       <= NOP;
      PC          <= 32'h0000_0000;
      PCPlus4     <= 32'h0000_0004;
    end else begin
      state_r     <= state_s;
      fetch_pc_r  <= fetch_pc_s;
      req_pc_r    <= grant_s ? fetch_pc_r : req_pc_r;
      rd_ptr_r    <= rd_ptr_s;
      wr_ptr_r    <= wr_ptr_s;
      count_r     <= count_s;
      imem_req    <= (state_s == REQ);
      instr_valid <= valid_s;
      Instr       <= instr_s;
      PC          <= pc_s;
      PCPlus4     <= pc_s + 32'd4;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: a memory model plus a
// program-order reference (sequential PCs from reset/redirect target).
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        instr_valid, instr_ready;
  logic [31:0] Instr, PC, PCPlus4;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PCSrc(PCSrc), .PCTarget(PCTarget),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_grants = 0;
  int          gnt_pct = 100, ready_pct = 100, redir_pct = 0, max_lat = 0;
  bit          hold_resp = 1'b0, force_redir = 1'b0;
  logic [31:0] force_target = 32'h0;
  logic [31:0] model_pc, out_addr, prev_addr, saved_addr;
  bit          out_valid = 1'b0, prev_redir = 1'b0, prev_stall = 1'b0, found;
  int          out_epoch = 0, epoch = 0, out_wait = 0, g0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},     32'(imem_req),    32'd0);
    chk({tag, "_addr"},    imem_addr,        RESET_PC);
    chk({tag, "_valid"},   32'(instr_valid), 32'd0);
    chk({tag, "_instr"},   Instr,            32'h0000_0013);
    chk({tag, "_pc"},      PC,               32'h0000_0000);
    chk({tag, "_pcplus4"}, PCPlus4,          32'h0000_0004);
  endtask

  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; PCSrc = 1'b0; PCTarget = 32'h0;
    exp_q.delete();
    out_valid = 1'b0; model_pc = RESET_PC; epoch++;
    prev_redir = 1'b0; prev_stall = 1'b0;
    #1;
    chk_reset_outputs(tag);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One clock cycle: check sampled outputs, drive inputs, advance the reference.
  task automatic step();
    @(posedge clk); #1;
    if (prev_redir) chk("valid_after_redirect", 32'(instr_valid), 32'd0);
    if (prev_stall) begin
      chk("addr_held_in_stall", imem_addr, prev_addr);
      chk("req_held_in_stall", 32'(imem_req), 32'd1);
    end
    if (out_valid) chk("single_outstanding", 32'(imem_req), 32'd0);

    imem_gnt    = imem_req && (int'($urandom_range(1, 100)) <= gnt_pct);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (out_valid && !hold_resp) begin
      if (out_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(out_addr);
      end else begin
        out_wait--;
      end
    end
    instr_ready = (int'($urandom_range(1, 100)) <= ready_pct);
    PCSrc       = force_redir || (int'($urandom_range(1, 100)) <= redir_pct);
    PCTarget    = force_redir ? force_target : $urandom;

    if (imem_rvalid) begin
      out_valid = 1'b0;
      if (out_epoch == epoch && !PCSrc) exp_q.push_back({out_addr, mem_word(out_addr)});
    end
    if (imem_req && imem_gnt) begin
      chk("fetch_addr", imem_addr, model_pc);
      n_grants++;
      out_valid = 1'b1;
      out_addr  = model_pc;
      out_epoch = epoch;
      out_wait  = int'($urandom_range(0, max_lat));
      model_pc  = model_pc + 32'd4;
    end
    if (PCSrc) begin
      epoch++;
      model_pc = PCTarget & ~32'h0000_0003;
    end
    prev_redir = PCSrc;
    prev_stall = imem_req && !imem_gnt && !PCSrc;
    prev_addr  = imem_addr;
  endtask

  // Monitor: every instruction handed to decode must be the next expected one.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_instr: got pc %h expected none", PC);
      end else begin
        e = exp_q.pop_front();
        chk("head_pc", PC, e.pc);
        chk("head_instr", Instr, e.instr);
        chk("head_pcplus4", PCPlus4, e.pc + 32'd4);
      end
    end
    if (PCSrc) exp_q.delete();
  end

  initial begin
    reset_n = 1'b1;
    #2;
    apply_reset("reset");
    step();
    chk("first_req", 32'(imem_req), 32'd1);
    repeat (20) step();

    // Back-pressure: queue fills, fetching stops, then drains in order.
    ready_pct = 0;
    repeat (10) step();
    chk("bp_queue_full", 32'(exp_q.size()), 32'(DEPTH));
    chk("bp_req_low", 32'(imem_req), 32'd0);
    chk("bp_valid", 32'(instr_valid), 32'd1);
    g0 = n_grants;
    ready_pct = 100;
    repeat (20) step();
    chk("bp_fetch_resumed", 32'(n_grants > g0), 32'd1);

    // Redirect while a response is outstanding.
    hold_resp = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = out_valid;
    end
    chk("wait_outstanding_found", 32'(found), 32'd1);
    force_redir = 1'b1; force_target = 32'h0000_0103;
    step();
    force_redir = 1'b0; hold_resp = 1'b0;
    repeat (12) step();

    // Redirect coinciding with rvalid and a pop, queue non-empty.
    repeat (10) step();
    ready_pct = 0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = out_valid && (exp_q.size() == 1);
    end
    chk("rv_redirect_setup_found", 32'(found), 32'd1);
    ready_pct = 100;
    force_redir = 1'b1; force_target = 32'h0000_0200;
    step();
    force_redir = 1'b0;
    step();
    chk("no_drain_req", 32'(imem_req), 32'd1);
    chk("no_drain_addr", imem_addr, 32'h0000_0200);
    repeat (10) step();

    // Wrap-around at the top of the address space.
    force_redir = 1'b1; force_target = 32'hFFFF_FFFC;
    step();
    force_redir = 1'b0;
    repeat (12) step();

    // Grant stall, then an asynchronous reset pulse in the middle of it.
    gnt_pct = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = imem_req;
    end
    chk("stall_req_found", 32'(found), 32'd1);
    saved_addr = imem_addr;
    repeat (5) step();
    chk("stall_addr_stable", imem_addr, saved_addr);
    #2;
    apply_reset("async_reset");
    gnt_pct = 100;
    step();
    chk("first_req_after_pulse", 32'(imem_req), 32'd1);
    repeat (10) step();

    // Random traffic.
    gnt_pct = 70; ready_pct = 60; redir_pct = 3; max_lat = 2;
    repeat (1500) step();

    // Final fill with decode stalled: nothing lost, fetching stops.
    gnt_pct = 100; ready_pct = 0; redir_pct = 0; max_lat = 0;
    repeat (15) step();
    chk("final_queue_full", 32'(exp_q.size()), 32'(DEPTH));
    chk("final_valid", 32'(instr_valid), 32'd1);
    chk("final_req_low", 32'(imem_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
